// File: rtl/updown_rate_counter_pkg.sv
// updown_rate_counter_pkg: shared constants and helpers for the rate counter
package updown_rate_counter_pkg;
  localparam logic [3:0] HEX_MAX = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int BTN_RATE_UP = 0;
  localparam int BTN_RATE_DN = 1;
  localparam int BTN_DIR = 2;
  function automatic int rate_w(int n);
    return $clog2(n);
  endfunction
  function automatic logic [3:0] clamp_nibble(logic [3:0] v, logic bcd);
    return (bcd && v > BCD_MAX) ? BCD_MAX : v;
  endfunction
endpackage

// File: rtl/updown_rate_counter_digit_step.sv
// digit_step: one hex/BCD nibble of the up/down count with carry/borrow chaining
module digit_step
  import updown_rate_counter_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_dir,
  input  logic       i_bcd,
  input  logic       i_carry_in,
  output logic [3:0] o_next,
  output logic       o_carry_out
);
  logic [3:0] w_v;
  logic [3:0] w_max;
  assign w_max = i_bcd ? BCD_MAX : HEX_MAX;
  assign w_v = clamp_nibble(i_value, i_bcd);
  always_comb begin
    o_carry_out = i_carry_in && (i_dir ? w_v == w_max : w_v == 4'd0);
    o_next = !i_carry_in ? w_v :
             o_carry_out ? (i_dir ? 4'd0 : w_max) :
             (i_dir ? w_v + 4'd1 : w_v - 4'd1);
  end
endmodule

// File: rtl/updown_rate_counter.sv
// updown_rate_counter: variable-rate up/down hex/BCD counter driven by a single
// prescaler that issues one-cycle count enables instead of divided clocks.
module updown_rate_counter
  import updown_rate_counter_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int NUM_RATES   = 10,
  parameter int STEP_CYCLES = 5_000_000
) (
  input  logic                          clck,
  input  logic                          reset,
  input  logic [2:0]                    btn,
  input  logic                          run,
  input  logic                          bcd,
  input  logic                          load,
  input  logic [4*DIGITS-1:0]           load_value,
  output logic [4*DIGITS-1:0]           count,
  output logic [rate_w(NUM_RATES)-1:0]  rate,
  output logic [NUM_RATES-1:0]          leds,
  output logic                          dir,
  output logic                          tick
);
  localparam int RW = rate_w(NUM_RATES);
  localparam int UW = $clog2(STEP_CYCLES + 1);
  localparam logic [RW-1:0] RATE_MAX = RW'(NUM_RATES - 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(STEP_CYCLES - 1);
  logic [2:0] r_s1, r_s2, r_s3;
  logic [RW-1:0] r_rate, r_per;
  logic [UW-1:0] r_unit;
  logic r_dir, r_tick;
  logic [4*DIGITS-1:0] r_count, w_next, w_load;
  logic [DIGITS:0] w_carry;
  logic [2:0] w_edge;
  logic [RW-1:0] w_per_last;
  logic w_up, w_dn, w_rate_ok, w_fire, w_unused_wrap;
  assign w_edge = r_s2 & ~r_s3;
  assign w_up = w_edge[BTN_RATE_UP] & ~w_edge[BTN_RATE_DN];
  assign w_dn = w_edge[BTN_RATE_DN] & ~w_edge[BTN_RATE_UP];
  assign w_rate_ok = (w_up && r_rate != RATE_MAX) || (w_dn && r_rate != '0);
  // faster rates shorten the period: NUM_RATES-rate units of STEP_CYCLES
  assign w_per_last = RATE_MAX - r_rate;
  assign w_fire = run && r_unit == UNIT_LAST && r_per == w_per_last;
  assign w_carry[0] = w_fire;
  assign w_unused_wrap = w_carry[DIGITS];
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    digit_step u_step (
      .i_value    (r_count[4*d +: 4]),
      .i_dir      (r_dir),
      .i_bcd      (bcd),
      .i_carry_in (w_carry[d]),
      .o_next     (w_next[4*d +: 4]),
      .o_carry_out(w_carry[d+1])
    );
    assign w_load[4*d +: 4] = clamp_nibble(load_value[4*d +: 4], bcd);
  end
  always_comb begin
    leds = '0;
    for (int i = 0; i < NUM_RATES; i++) leds[i] = i <= int'(r_rate);
  end
  always_ff @(posedge clck) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_rate <= '0;
      r_per <= '0;
      r_unit <= '0;
      r_dir <= 1'b1;
      r_tick <= 1'b0;
      r_count <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_tick <= w_fire;
      if (w_edge[BTN_DIR]) r_dir <= ~r_dir;
      if (w_rate_ok) r_rate <= w_up ? r_rate + 1'b1 : r_rate - 1'b1;
      if (!run || w_rate_ok) begin
        r_unit <= '0;
        r_per <= '0;
      end else if (r_unit == UNIT_LAST) begin
        r_unit <= '0;
        r_per <= (r_per == w_per_last) ? '0 : r_per + 1'b1;
      end else begin
        r_unit <= r_unit + 1'b1;
      end
      if (load) r_count <= w_load;
      else if (w_fire) r_count <= w_next;
    end
  end
  assign count = r_count;
  assign rate = r_rate;
  assign dir = r_dir;
  assign tick = r_tick;
endmodule

// File: tb/tb_updown_rate_counter.sv
// tb_updown_rate_counter: scoreboard bench; expected ticks are queued by the
// stimulus and a monitor checks count and tick spacing on every tick pulse.
module tb_updown_rate_counter;
  logic clck = 1'b0;
  logic reset = 1'b1;
  logic [2:0] btn = '0;
  logic run = 1'b1;
  logic bcd = 1'b0;
  logic load = 1'b0;
  logic [7:0] load_value = '0;
  logic [7:0] count;
  logic [3:0] rate;
  logic [9:0] leds;
  logic dir, tick;
  typedef struct {
    logic [7:0] c;
    int gap;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last = 0;
  int nticks = 0;
  logic [3:0] prev_rate = '0;

  updown_rate_counter #(.DIGITS(2), .NUM_RATES(10), .STEP_CYCLES(4)) dut (
    .clck(clck), .reset(reset), .btn(btn), .run(run), .bcd(bcd), .load(load),
    .load_value(load_value), .count(count), .rate(rate), .leds(leds),
    .dir(dir), .tick(tick)
  );

  always #5 clck = ~clck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: tick spacing is measured from the last edge that restarted the prescaler
  always @(posedge clck) begin
    #1;
    cyc++;
    if (tick) begin
      nticks++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tick_unexpected count=%h required=no_tick", count);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_count", 32'(count), 32'(e.c));
        if (e.gap != 0) chk("tick_gap", cyc - last, e.gap);
      end
      last = cyc;
    end
    if (reset || !run || rate != prev_rate) last = cyc;
    prev_rate = rate;
  end

  task automatic expect_tick(input logic [7:0] c, input int gap);
    exp_t e;
    e.c = c;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_q(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clck);
      n++;
    end
    chk("queue_drain", q.size(), 0);
    q.delete();
  endtask

  task automatic press(input logic [2:0] b);
    @(negedge clck);
    btn = b;
    @(negedge clck);
    btn = '0;
    repeat (4) @(negedge clck);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clck);
    load = 1'b1;
    load_value = v;
    @(negedge clck);
    load = 1'b0;
  endtask

  task automatic run_ticks(input logic [7:0] c0, input logic [7:0] c1, input int gap, input int n);
    @(negedge clck);
    expect_tick(c0, gap);
    if (n > 1) expect_tick(c1, gap);
    run = 1'b1;
    wait_q(gap * n + 20);
    run = 1'b0;
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clck);
    chk("rst_count", 32'(count), 0);
    chk("rst_rate", 32'(rate), 0);
    chk("rst_leds", 32'(leds), 1);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_tick", 32'(tick), 0);
    expect_tick(8'h01, 40);
    expect_tick(8'h02, 40);
    reset = 1'b0;
    wait_q(200);
    run = 1'b0;
    repeat (3) press(3'b001);
    chk("rate_3", 32'(rate), 3);
    chk("leds_3", 32'(leds), 32'b0000001111);
    run_ticks(8'h03, 8'h04, 28, 2);
    repeat (12) press(3'b001);
    chk("rate_sat_hi", 32'(rate), 9);
    chk("leds_9", 32'(leds), 32'h3FF);
    run_ticks(8'h05, 8'h06, 4, 2);
    repeat (10) press(3'b010);
    chk("rate_sat_lo", 32'(rate), 0);
    chk("leds_0", 32'(leds), 1);
    bcd = 1'b1;
    do_load(8'h98);
    chk("load_98", 32'(count), 32'h98);
    run_ticks(8'h99, 8'h00, 40, 2);
    press(3'b100);
    chk("dir_down", 32'(dir), 0);
    run_ticks(8'h99, 8'h98, 40, 2);
    bcd = 1'b0;
    do_load(8'h00);
    run_ticks(8'hFF, 8'h00, 40, 1);
    bcd = 1'b1;
    do_load(8'hAC);
    chk("load_clamp", 32'(count), 32'h99);
    bcd = 1'b0;
    do_load(8'hAC);
    chk("load_hex", 32'(count), 32'hAC);
    bcd = 1'b1;
    press(3'b100);
    chk("dir_up", 32'(dir), 1);
    run_ticks(8'h00, 8'h00, 40, 1);
    repeat (2) press(3'b001);
    chk("rate_2", 32'(rate), 2);
    @(negedge clck);
    expect_tick(8'h01, 32);
    expect_tick(8'h02, 32);
    run = 1'b1;
    repeat (10) @(negedge clck);
    btn = 3'b011;
    @(negedge clck);
    btn = '0;
    wait_q(100);
    run = 1'b0;
    chk("rate_both", 32'(rate), 2);
    @(negedge clck);
    expect_tick(8'h55, 32);
    run = 1'b1;
    repeat (31) @(negedge clck);
    load = 1'b1;
    load_value = 8'h55;
    @(negedge clck);
    load = 1'b0;
    run = 1'b0;
    wait_q(10);
    chk("load_over_tick", 32'(count), 32'h55);
    repeat (3) press(3'b001);
    chk("rate_5", 32'(rate), 5);
    press(3'b100);
    do_load(8'h37);
    run_ticks(8'h36, 8'h00, 20, 1);
    chk("pre_rst_dir", 32'(dir), 0);
    run = 1'b1;
    repeat (5) @(negedge clck);
    reset = 1'b1;
    load = 1'b1;
    load_value = 8'h12;
    @(negedge clck);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_rate", 32'(rate), 0);
    chk("midrst_dir", 32'(dir), 1);
    chk("midrst_leds", 32'(leds), 1);
    chk("midrst_tick", 32'(tick), 0);
    load = 1'b0;
    run = 1'b0;
    @(negedge clck);
    reset = 1'b0;
    t0 = nticks;
    repeat (200) @(negedge clck);
    chk("hold_ticks", nticks - t0, 0);
    chk("hold_count", 32'(count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
